z80_bus_bridge: RTL and testbench

Bus-cycle bridge that sits directly downstream of the negative-pin A-Z80 top level. It watches the CPU's active-low control pins, address and data. It classifies each bus cycle, then issues one request/acknowledge transaction per cycle to a single memory/IO slave. While the slave is busy it holds the CPU in wait states through nWAIT, and it returns read data to the CPU data bus.

---
 rtl/z80_bus_bridge.sv | 129 ++++++++++++
 tb/tb_z80_bus_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - A-Z80 pin-level bus cycle to req/ack slave bridge with wait-state insertion
module z80_bus_bridge #(
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        nWAIT,
  output logic        req,
  output logic        we,
  output logic        io,
  output logic        m1,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] MIN_W = 8'(MIN_WAIT);
  localparam logic [7:0] TO_W  = 8'(TIMEOUT);

  state_t     state;
  logic       armed;
  logic       ack_seen;
  logic [7:0] wait_cnt;
  logic [7:0] to_cnt;
  logic [7:0] wait_nxt;
  logic [7:0] to_nxt;
  logic       bus_idle, mem_ok;
  logic       is_fetch, is_mrd, is_mwr, is_ird, is_iwr, is_inta;
  logic       start, dec_we, dec_io, dec_m1;
  logic       min_met, timed_out;

  always_comb begin
    bus_idle = nMREQ & nIORQ;
    // refresh drives MREQ low with RFSH low; masking it here keeps it from ever qualifying
    mem_ok   = ~nMREQ & nRFSH;
    is_fetch = mem_ok & ~nM1 & ~nRD;
    is_mrd   = mem_ok & nM1 & ~nRD;
    is_mwr   = mem_ok & ~nWR;
    is_ird   = ~nIORQ & ~nRD & nM1;
    is_iwr   = ~nIORQ & ~nWR;
    is_inta  = ~nM1 & ~nIORQ;
    start    = (state == IDLE) & armed &
               (is_fetch | is_mrd | is_mwr | is_ird | is_iwr | is_inta);
    dec_we   = (is_mwr | is_iwr) & ~is_inta;
    dec_io   = is_ird | is_iwr | is_inta;
    dec_m1   = is_fetch | is_inta;
    // counts include the current REQ cycle so cycle k compares as k
    wait_nxt  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    to_nxt    = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
    min_met   = (wait_nxt >= MIN_W);
    timed_out = (to_nxt == TO_W) & ~ack & ~ack_seen;
    nWAIT     = ~(start | (state == REQ));
    D_oe      = (state == DONE) & ~we & ~nRD;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      armed    <= 1'b0;
      ack_seen <= 1'b0;
      wait_cnt <= 8'd0;
      to_cnt   <= 8'd0;
      req      <= 1'b0;
      we       <= 1'b0;
      io       <= 1'b0;
      m1       <= 1'b0;
      addr     <= 16'd0;
      wdata    <= 8'd0;
      D_out    <= 8'd0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bus_idle) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            req      <= 1'b1;
            addr     <= A;
            we       <= dec_we;
            io       <= dec_io;
            m1       <= dec_m1;
            wdata    <= D_in;
            wait_cnt <= 8'd0;
            to_cnt   <= 8'd0;
            ack_seen <= 1'b0;
          end
        end
        REQ: begin
          wait_cnt <= wait_nxt;
          to_cnt   <= to_nxt;
          if (ack) begin
            ack_seen <= 1'b1;
            D_out    <= rdata;
          end
          if ((ack_seen | ack) & min_met) begin
            state <= DONE;
            req   <= 1'b0;
          end else if (timed_out) begin
            state <= DONE;
            req   <= 1'b0;
            err   <= 1'b1;
            D_out <= 8'hFF;
          end
        end
        DONE: begin
          if (bus_idle) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb/tb_z80_bus_bridge.sv - directed bench for z80_bus_bridge, two parameterisations side by side
module tb_z80_bus_bridge;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        nM1 = 1'b1, nMREQ = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nRFSH = 1'b1;
  logic [15:0] A = 16'd0;
  logic [7:0]  D_in = 8'd0, rdata = 8'd0;
  logic        ack_a = 1'b0, ack_b = 1'b0;

  logic [7:0]  D_out_a, wdata_a, D_out_b, wdata_b;
  logic [15:0] addr_a, addr_b;
  logic        D_oe_a, nWAIT_a, req_a, we_a, io_a, m1_a, err_a;
  logic        D_oe_b, nWAIT_b, req_b, we_b, io_b, m1_b, err_b;

  int vecs = 0;
  int fails = 0;

  // per-transaction observations
  int          lo_a, lo_b, ia, ib, rise_a, err_n;
  logic        prev_req;
  logic        cap_we, cap_io, cap_m1;
  logic [15:0] cap_addr;
  logic [7:0]  end_dout_a;
  logic        end_doe_a, end_nwait_a;

  always #5 CLK = ~CLK;

  z80_bus_bridge #(.MIN_WAIT(0), .TIMEOUT(4)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(D_out_a), .D_oe(D_oe_a),
    .nWAIT(nWAIT_a), .req(req_a), .we(we_a), .io(io_a), .m1(m1_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata), .ack(ack_a), .err(err_a)
  );

  z80_bus_bridge #(.MIN_WAIT(3), .TIMEOUT(255)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(D_out_b), .D_oe(D_oe_b),
    .nWAIT(nWAIT_b), .req(req_b), .we(we_b), .io(io_b), .m1(m1_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata), .ack(ack_b), .err(err_b)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_pins();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
  endtask

  // holds the pins for 10 cycles, acks each slave on REQ cycle ka/kb (0 = never), then releases the bus
  task automatic txn(input logic [15:0] a, input logic m1n, input logic mreqn, input logic iorqn,
                     input logic rdn, input logic wrn, input logic rfshn, input logic [7:0] din,
                     input logic [7:0] rd, input int ka, input int kb);
    A = a; nM1 = m1n; nMREQ = mreqn; nIORQ = iorqn; nRD = rdn; nWR = wrn; nRFSH = rfshn;
    D_in = din; rdata = rd;
    lo_a = 0; lo_b = 0; ia = 0; ib = 0; rise_a = 0; err_n = 0; prev_req = 1'b0;
    cap_we = 1'bx; cap_io = 1'bx; cap_m1 = 1'bx; cap_addr = 16'hxxxx;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!nWAIT_a) lo_a++;
      if (!nWAIT_b) lo_b++;
      if (err_a) err_n++;
      if (req_a && !prev_req) rise_a++;
      prev_req = req_a;
      if (req_a) begin
        ia++;
        if (ia == 1) begin cap_we = we_a; cap_io = io_a; cap_m1 = m1_a; cap_addr = addr_a; end
      end
      if (req_b) ib++;
      ack_a = req_a && (ia == ka);
      ack_b = req_b && (ib == kb);
      tick();
    end
    ack_a = 1'b0; ack_b = 1'b0;
    #1;
    end_dout_a = D_out_a; end_doe_a = D_oe_a; end_nwait_a = nWAIT_a;
    idle_pins();
    tick();
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_pins();
    tick(); tick();
    vecs++; if (req_a !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", req_a); end
    vecs++; if (nWAIT_a !== 1'b1) begin fails++; $display("FAIL rst_nwait got %b exp 1", nWAIT_a); end
    vecs++; if ({we_a, io_a, m1_a, D_oe_a, err_a} !== 5'b0) begin fails++; $display("FAIL rst_flags got %b exp 00000", {we_a, io_a, m1_a, D_oe_a, err_a}); end
    vecs++; if ({addr_a, wdata_a, D_out_a} !== 32'd0) begin fails++; $display("FAIL rst_regs got %h exp 0", {addr_a, wdata_a, D_out_a}); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_mem_read();
    txn(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5A, 1, 1);
    vecs++; if (lo_a !== 2) begin fails++; $display("FAIL rd_nwait_low got %0d exp 2", lo_a); end
    vecs++; if (ia !== 1) begin fails++; $display("FAIL rd_req_cycles got %0d exp 1", ia); end
    vecs++; if (rise_a !== 1) begin fails++; $display("FAIL rd_req_rises got %0d exp 1", rise_a); end
    vecs++; if ({cap_we, cap_io, cap_m1} !== 3'b000) begin fails++; $display("FAIL rd_kind got %b exp 000", {cap_we, cap_io, cap_m1}); end
    vecs++; if (cap_addr !== 16'h1234) begin fails++; $display("FAIL rd_addr got %h exp 1234", cap_addr); end
    vecs++; if (end_dout_a !== 8'h5A) begin fails++; $display("FAIL rd_dout got %h exp 5a", end_dout_a); end
    vecs++; if (end_doe_a !== 1'b1) begin fails++; $display("FAIL rd_doe got %b exp 1", end_doe_a); end
    vecs++; if (D_oe_a !== 1'b0) begin fails++; $display("FAIL rd_doe_release got %b exp 0", D_oe_a); end
    vecs++; if (lo_b !== 4) begin fails++; $display("FAIL rd_minwait_low got %0d exp 4", lo_b); end
  endtask

  task automatic test_mem_write();
    // MREQ low without WR must not start anything
    A = 16'h8000; nMREQ = 1'b0; D_in = 8'hC3;
    #1;
    vecs++; if (nWAIT_a !== 1'b1) begin fails++; $display("FAIL wr_mreq_only_nwait got %b exp 1", nWAIT_a); end
    tick();
    vecs++; if (req_a !== 1'b0) begin fails++; $display("FAIL wr_mreq_only_req got %b exp 0", req_a); end
    txn(16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 1, 1);
    vecs++; if (lo_b !== 4) begin fails++; $display("FAIL wr_minwait_low got %0d exp 4", lo_b); end
    vecs++; if (ib !== 3) begin fails++; $display("FAIL wr_minwait_req got %0d exp 3", ib); end
    vecs++; if ({we_b, io_b, wdata_b} !== {2'b10, 8'hC3}) begin fails++; $display("FAIL wr_latch got %b/%b/%h exp 1/0/c3", we_b, io_b, wdata_b); end
    vecs++; if (lo_a !== 2) begin fails++; $display("FAIL wr_nwait_low got %0d exp 2", lo_a); end
    vecs++; if (end_doe_a !== 1'b0) begin fails++; $display("FAIL wr_doe got %b exp 0", end_doe_a); end
  endtask

  task automatic test_fetch_refresh();
    txn(16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h3E, 1, 1);
    vecs++; if (rise_a !== 1) begin fails++; $display("FAIL fetch_rises got %0d exp 1", rise_a); end
    vecs++; if ({cap_we, cap_io, cap_m1} !== 3'b001) begin fails++; $display("FAIL fetch_kind got %b exp 001", {cap_we, cap_io, cap_m1}); end
    txn(16'h0042, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1, 1);
    vecs++; if (rise_a !== 0) begin fails++; $display("FAIL rfsh_rises got %0d exp 0", rise_a); end
    vecs++; if (lo_a + lo_b !== 0) begin fails++; $display("FAIL rfsh_nwait_low got %0d exp 0", lo_a + lo_b); end
  endtask

  task automatic test_int_ack();
    txn(16'h0038, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 1, 1);
    vecs++; if ({cap_we, cap_io, cap_m1} !== 3'b011) begin fails++; $display("FAIL inta_kind got %b exp 011", {cap_we, cap_io, cap_m1}); end
    vecs++; if (end_dout_a !== 8'hFF) begin fails++; $display("FAIL inta_dout got %h exp ff", end_dout_a); end
    vecs++; if (err_n !== 0) begin fails++; $display("FAIL inta_err got %0d exp 0", err_n); end
  endtask

  task automatic test_io_read();
    txn(16'h001F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h77, 2, 1);
    vecs++; if ({cap_we, cap_io, cap_m1} !== 3'b010) begin fails++; $display("FAIL iord_kind got %b exp 010", {cap_we, cap_io, cap_m1}); end
    vecs++; if (lo_a !== 3) begin fails++; $display("FAIL iord_nwait_low got %0d exp 3", lo_a); end
    vecs++; if (end_dout_a !== 8'h77) begin fails++; $display("FAIL iord_dout got %h exp 77", end_dout_a); end
  endtask

  task automatic test_ack_at_timeout();
    txn(16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h3C, 4, 1);
    vecs++; if (err_n !== 0) begin fails++; $display("FAIL tie_err got %0d exp 0", err_n); end
    vecs++; if (end_dout_a !== 8'h3C) begin fails++; $display("FAIL tie_dout got %h exp 3c", end_dout_a); end
    vecs++; if (lo_a !== 5) begin fails++; $display("FAIL tie_nwait_low got %0d exp 5", lo_a); end
  endtask

  task automatic test_timeout();
    txn(16'h00FE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 0, 1);
    vecs++; if (ia !== 4) begin fails++; $display("FAIL to_req_cycles got %0d exp 4", ia); end
    vecs++; if (err_n !== 1) begin fails++; $display("FAIL to_err_pulses got %0d exp 1", err_n); end
    vecs++; if (lo_a !== 5) begin fails++; $display("FAIL to_nwait_low got %0d exp 5", lo_a); end
    vecs++; if (end_nwait_a !== 1'b1) begin fails++; $display("FAIL to_nwait_end got %b exp 1", end_nwait_a); end
    vecs++; if (end_dout_a !== 8'hFF) begin fails++; $display("FAIL to_dout got %h exp ff", end_dout_a); end
    vecs++; if (err_a !== 1'b0) begin fails++; $display("FAIL to_err_after got %b exp 0", err_a); end
  endtask

  task automatic test_reset_mid_txn();
    A = 16'h2222; nMREQ = 1'b0; nRD = 1'b0; rdata = 8'h99;
    tick(); tick();
    vecs++; if (req_a !== 1'b1) begin fails++; $display("FAIL mid_req_before got %b exp 1", req_a); end
    ack_a = 1'b1;
    RESET = 1'b1;
    #1;
    vecs++; if ({req_a, nWAIT_a, we_a, D_oe_a} !== 4'b0100) begin fails++; $display("FAIL mid_async got %b exp 0100", {req_a, nWAIT_a, we_a, D_oe_a}); end
    vecs++; if ({addr_a, D_out_a} !== 24'd0) begin fails++; $display("FAIL mid_regs got %h exp 0", {addr_a, D_out_a}); end
    tick();
    ack_a = 1'b0;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if ({req_a, nWAIT_a} !== 2'b01) begin fails++; $display("FAIL mid_unarmed cyc %0d got %b exp 01", i, {req_a, nWAIT_a}); end
      tick();
    end
    vecs++; if (D_out_a !== 8'h00) begin fails++; $display("FAIL mid_ack_dropped got %h exp 00", D_out_a); end
    idle_pins();
    tick();
    txn(16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h66, 1, 1);
    vecs++; if (rise_a !== 1) begin fails++; $display("FAIL post_rst_rises got %0d exp 1", rise_a); end
    vecs++; if (lo_a !== 2) begin fails++; $display("FAIL post_rst_nwait_low got %0d exp 2", lo_a); end
    vecs++; if (end_dout_a !== 8'h66) begin fails++; $display("FAIL post_rst_dout got %h exp 66", end_dout_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_fetch_refresh();
    test_int_ack();
    test_io_read();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_txn();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
